// File: rtl/sel_data_out_rr.sv
// Round-robin drain engine: merges NUM_CH first-word-fall-through FIFOs into
// one registered output stream tagged with the source channel ID.
// SKIP_EMPTY=1 grants only non-empty channels; SKIP_EMPTY=0 walks one channel
// slot per output beat and emits a zero word for an empty slot.
module sel_data_out_rr #(
   parameter int NUM_CH     = 80,
   parameter int DATA_W     = 395,
   parameter int CHID_W     = 7,
   parameter int SKIP_EMPTY = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic [NUM_CH-1:0]        fifo_empty,
   input  logic [NUM_CH*DATA_W-1:0] fifo_data,
   output logic [NUM_CH-1:0]        fifo_read_enable,
   output logic [DATA_W-1:0]        data_out,
   output logic [CHID_W-1:0]        chid_value,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state_q;
   logic [CHID_W-1:0]   ptr_q;
   logic [DATA_W-1:0]   data_q;
   logic [CHID_W-1:0]   chid_q;
   logic                valid_q;

   logic                load;
   logic                gnt_vld;
   logic [CHID_W-1:0]   gnt_idx;
   logic [CHID_W-1:0]   ptr_d;
   logic [DATA_W-1:0]   gnt_word;
   int                  idx;

   // A new beat may be taken only while running, not stopping, not in reset,
   // and when the output register is empty or being drained this cycle.
   assign load = (state_q == RUN) && !stop && !rst && (!valid_q || out_ready);

   // Grant selection: wrap-around search from ptr, or the fixed ptr slot.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = ptr_q;
      idx     = 0;
      if (SKIP_EMPTY != 0) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_vld && !fifo_empty[idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = CHID_W'(idx);
            end
         end
      end else begin
         gnt_vld = !fifo_empty[int'(ptr_q)];
      end
   end

   // Next pointer is one past the granted slot, wrapping at NUM_CH.
   always_comb begin
      ptr_d = '0;
      if (int'(gnt_idx) != NUM_CH - 1) ptr_d = gnt_idx + 1'b1;
   end

   // Head word of the granted channel.
   always_comb begin
      gnt_word = fifo_data[int'(gnt_idx)*DATA_W +: DATA_W];
   end

   // Pop strobe: at most one bit, never on an empty channel.
   always_comb begin
      fifo_read_enable = '0;
      if (load && gnt_vld) fifo_read_enable[int'(gnt_idx)] = 1'b1;
   end

   // Control FSM plus output/pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         data_q  <= '0;
         chid_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (load) begin
            if (SKIP_EMPTY != 0) begin
               if (gnt_vld) begin
                  data_q  <= gnt_word;
                  chid_q  <= gnt_idx;
                  valid_q <= 1'b1;
                  ptr_q   <= ptr_d;
               end else begin
                  valid_q <= 1'b0;
               end
            end else begin
               // Empty slot still produces a beat, carrying a zero word.
               data_q  <= gnt_vld ? gnt_word : '0;
               chid_q  <= gnt_idx;
               valid_q <= 1'b1;
               ptr_q   <= ptr_d;
            end
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE:    if (start && !stop) state_q <= RUN;
            RUN:     if (stop) state_q <= DRAIN;
            DRAIN:   if (!valid_q || out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out   = data_q;
   assign chid_value = chid_q;
   assign out_valid  = valid_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sel_data_out_rr.sv
// Directed bench for sel_data_out_rr with NUM_CH=4, DATA_W=8: one instance in
// skip-empty mode (u1) and one in fixed-scan mode (u0), driven independently.
module tb_sel_data_out_rr;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] heads = 32'hA3A2A1A0;

   logic       rst1, start1, stop1, ready1, valid1, busy1;
   logic [3:0] empty1, rd1;
   logic [7:0] dout1;
   logic [1:0] chid1;

   logic       rst0, start0, stop0, ready0, valid0, busy0;
   logic [3:0] empty0, rd0;
   logic [7:0] dout0;
   logic [1:0] chid0;

   int ntests = 0;
   int nfail  = 0;

   sel_data_out_rr #(.NUM_CH(4), .DATA_W(8), .CHID_W(2), .SKIP_EMPTY(1)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .stop(stop1),
      .fifo_empty(empty1), .fifo_data(heads), .fifo_read_enable(rd1),
      .data_out(dout1), .chid_value(chid1), .out_valid(valid1),
      .out_ready(ready1), .busy(busy1));

   sel_data_out_rr #(.NUM_CH(4), .DATA_W(8), .CHID_W(2), .SKIP_EMPTY(0)) u0 (
      .clk(clk), .rst(rst0), .start(start0), .stop(stop0),
      .fifo_empty(empty0), .fifo_data(heads), .fifo_read_enable(rd0),
      .data_out(dout0), .chid_value(chid0), .out_valid(valid0),
      .out_ready(ready0), .busy(busy0));

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic out1(input string tag, input int v, input int c, input int d);
      chk({tag, ".valid"}, 32'(valid1), v);
      chk({tag, ".chid"},  32'(chid1),  c);
      chk({tag, ".data"},  32'(dout1),  d);
   endtask

   task automatic out0(input string tag, input int v, input int c, input int d);
      chk({tag, ".valid"}, 32'(valid0), v);
      chk({tag, ".chid"},  32'(chid0),  c);
      chk({tag, ".data"},  32'(dout0),  d);
   endtask

   initial begin
      int g[4];
      int c;
      g = '{3, 1, 3, 1};

      rst1 = 1; start1 = 0; stop1 = 0; ready1 = 1; empty1 = 4'b1111;
      rst0 = 1; start0 = 0; stop0 = 0; ready0 = 1; empty0 = 4'b1111;

      // Reset state
      cyc;
      empty1 = 4'b0000;
      settle;
      chk("rst_rd1", 32'(rd1), 0);
      cyc;
      out1("rst1", 0, 0, 0);
      chk("rst_busy1", 32'(busy1), 0);
      out0("rst0", 0, 0, 0);
      chk("rst_busy0", 32'(busy0), 0);
      rst1 = 0; rst0 = 0;

      // Skip-empty, all channels full: strict rotation 0,1,2,3,0,1
      start1 = 1;
      settle;
      chk("idle_rd1", 32'(rd1), 0);
      cyc;
      start1 = 0;
      for (int i = 0; i < 6; i++) begin
         settle;
         chk("rot_rd", 32'(rd1), 1 << (i % 4));
         cyc;
         out1("rot_out", 1, i % 4, 'hA0 + (i % 4));
      end
      chk("rot_busy", 32'(busy1), 1);

      // Stop with ready high: one drain cycle then IDLE
      stop1 = 1;
      settle;
      chk("stop_rd", 32'(rd1), 0);
      cyc;
      stop1 = 0;
      chk("drain_busy", 32'(busy1), 1);
      chk("drain_valid", 32'(valid1), 0);
      cyc;
      chk("idle_busy", 32'(busy1), 0);

      // Only channels 1 and 3 non-empty, ptr retained at 2: grants 3,1,3,1
      empty1 = 4'b0101;
      start1 = 1;
      cyc;
      start1 = 0;
      for (int i = 0; i < 4; i++) begin
         settle;
         chk("skip_rd", 32'(rd1), 1 << g[i]);
         cyc;
         out1("skip_out", 1, g[i], 'hA0 + g[i]);
      end

      // All empty: valid drops, ptr held at 2
      empty1 = 4'b1111;
      settle;
      chk("allempty_rd", 32'(rd1), 0);
      cyc;
      chk("allempty_valid", 32'(valid1), 0);
      empty1 = 4'b0000;
      settle;
      chk("ptr_held_rd", 32'(rd1), 'b0100);
      cyc;
      out1("ptr_held_out", 1, 2, 'hA2);

      // Backpressure for 3 cycles holds word A2/2 and the pointer
      ready1 = 0;
      settle;
      chk("bp_rd0", 32'(rd1), 0);
      for (int i = 0; i < 3; i++) begin
         cyc;
         out1("bp_hold", 1, 2, 'hA2);
         chk("bp_rd", 32'(rd1), 0);
      end
      ready1 = 1;
      settle;
      chk("bp_release_rd", 32'(rd1), 'b1000);
      cyc;
      out1("bp_release_out", 1, 3, 'hA3);

      // Stop under backpressure: DRAIN holds the beat, start ignored
      ready1 = 0;
      stop1 = 1;
      settle;
      chk("stopbp_rd", 32'(rd1), 0);
      cyc;
      stop1 = 0;
      chk("stopbp_busy", 32'(busy1), 1);
      out1("stopbp_hold", 1, 3, 'hA3);
      start1 = 1;
      settle;
      chk("drain_start_rd", 32'(rd1), 0);
      cyc;
      start1 = 0;
      chk("drain_start_busy", 32'(busy1), 1);
      chk("drain_start_valid", 32'(valid1), 1);
      ready1 = 1;
      cyc;
      chk("drained_busy", 32'(busy1), 0);
      chk("drained_valid", 32'(valid1), 0);

      // start and stop together in IDLE: stays IDLE
      start1 = 1;
      stop1 = 1;
      cyc;
      start1 = 0;
      stop1 = 0;
      chk("startstop_busy", 32'(busy1), 0);
      settle;
      chk("startstop_rd", 32'(rd1), 0);

      // Reset mid-run with a valid beat out; restart from ptr 0
      empty1 = 4'b0001;
      start1 = 1;
      cyc;
      start1 = 0;
      settle;
      chk("pre_rst_rd", 32'(rd1), 'b0010);
      cyc;
      out1("pre_rst_out", 1, 1, 'hA1);
      settle;
      chk("pre_rst_rd2", 32'(rd1), 'b0100);
      rst1 = 1;
      settle;
      chk("in_rst_rd", 32'(rd1), 0);
      cyc;
      rst1 = 0;
      out1("post_rst", 0, 0, 0);
      chk("post_rst_busy", 32'(busy1), 0);
      start1 = 1;
      cyc;
      start1 = 0;
      settle;
      chk("restart_rd", 32'(rd1), 'b0010);
      cyc;
      out1("restart_out", 1, 1, 'hA1);

      // Fixed scan, channel 2 empty: zero word at slot 2, never popped
      empty0 = 4'b0100;
      start0 = 1;
      cyc;
      start0 = 0;
      for (int i = 0; i < 5; i++) begin
         c = i % 4;
         settle;
         chk("scan_rd", 32'(rd0), (c == 2) ? 0 : (1 << c));
         cyc;
         out0("scan_out", 1, c, (c == 2) ? 0 : ('hA0 + c));
      end

      // Reset mid-run in fixed-scan mode; first grant afterwards is channel 0
      rst0 = 1;
      settle;
      chk("scan_in_rst_rd", 32'(rd0), 0);
      cyc;
      rst0 = 0;
      out0("scan_post_rst", 0, 0, 0);
      chk("scan_post_rst_busy", 32'(busy0), 0);
      start0 = 1;
      cyc;
      start0 = 0;
      settle;
      chk("scan_restart_rd", 32'(rd0), 'b0001);
      cyc;
      out0("scan_restart_out", 1, 0, 'hA0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
